fpu_adder_core: RTL

Single-precision IEEE-754 floating-point adder, the responder end of the `input_a`/`input_b`/`output_z` strobe/acknowledge protocol driven by HLS-generated `fpu_add` initiators.
- Accepts operand A, then operand B, each via a stb/ack handshake.
- Computes A+B with round-to-nearest-even in a fixed five-cycle multi-cycle datapath.
- Presents the result with a one-cycle `output_z_stb` pulse, then returns to waiting for A.

---
 rtl/fpu_pkg.sv | 33 +++
 rtl/fpu_adder_core_if.sv | 24 ++
 rtl/fpu_lzc28.sv | 15 +
 rtl/fpu_adder_core.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared types, constants and field helpers for the binary32 adder core.
package fpu_pkg;

  typedef enum logic [2:0] {
    GET_A = 3'd0,
    GET_B = 3'd1,
    ALIGN = 3'd2,
    ADD   = 3'd3,
    NORM  = 3'd4,
    ROUND = 3'd5,
    PUT_Z = 3'd6
  } fpu_state_t;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int EXT_W = 27;

  localparam logic [31:0] FP_QNAN = 32'h7FC00000;
  localparam logic [31:0] FP_INF  = 32'h7F800000;

  function automatic logic fp_sign(input logic [31:0] v);
    return v[31];
  endfunction

  function automatic logic [EXP_W-1:0] fp_exp(input logic [31:0] v);
    return v[30:23];
  endfunction

  function automatic logic [MAN_W-1:0] fp_man(input logic [31:0] v);
    return v[22:0];
  endfunction

endpackage

// File: rtl/fpu_adder_core_if.sv
// Operand/result strobe-acknowledge bundle between an fpu_add initiator and the core.
interface fpu_adder_core_if;
  import fpu_pkg::*;

  logic [31:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [31:0] input_b;
  logic        input_b_stb;
  logic        input_b_ack;
  logic [31:0] output_z;
  logic        output_z_stb;

  modport master (
    output input_a, input_a_stb, input_b, input_b_stb,
    input  input_a_ack, input_b_ack, output_z, output_z_stb
  );

  modport slave (
    input  input_a, input_a_stb, input_b, input_b_stb,
    output input_a_ack, input_b_ack, output_z, output_z_stb
  );

endinterface

// File: rtl/fpu_lzc28.sv
// Combinational leading-zero counter over a 28-bit word; all-zero input yields 28.
module fpu_lzc28 (
  input  logic [27:0] i_val,
  output logic [4:0]  o_lz
);

  // Highest set bit wins because later iterations overwrite earlier ones.
  always_comb begin
    o_lz = 5'd28;
    for (int i = 0; i < 28; i++) begin
      o_lz = i_val[i] ? 5'(27 - i) : o_lz;
    end
  end

endmodule

// File: rtl/fpu_adder_core.sv
// Multi-cycle binary32 adder: captures A then B, aligns/adds/normalises/rounds (RNE),
// and presents the sum with a one-cycle strobe. Denormals are flushed to zero.
module fpu_adder_core
  import fpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  fpu_adder_core_if.slave  bus
);

  fpu_state_t r_state;
  fpu_state_t w_next;

  logic              r_a_ack;
  logic              r_b_ack;
  logic              r_z_stb;
  logic [31:0]       r_z;
  logic [31:0]       r_a;
  logic [31:0]       r_b;
  logic              r_special;
  logic [31:0]       r_special_z;
  logic              r_sign;
  logic              r_sign_s;
  logic              r_res_zero;
  logic signed [9:0] r_exp;
  logic [EXT_W-1:0]  r_man_l;
  logic [EXT_W-1:0]  r_man_s;
  logic [EXT_W:0]    r_sum;

  logic              w_a_fire;
  logic              w_b_fire;

  // Unpacked operand fields (exponent 0 is treated as zero).
  logic              w_sa;
  logic              w_sb;
  logic [EXP_W-1:0]  w_ea;
  logic [EXP_W-1:0]  w_eb;
  logic [MAN_W-1:0]  w_fa;
  logic [MAN_W-1:0]  w_fb;
  logic              w_a_zero;
  logic              w_b_zero;
  logic              w_a_inf;
  logic              w_b_inf;
  logic              w_a_nan;
  logic              w_b_nan;
  logic [23:0]       w_ma;
  logic [23:0]       w_mb;
  logic              w_a_ge;
  logic [EXP_W-1:0]  w_el;
  logic [EXP_W-1:0]  w_es;
  logic [EXP_W-1:0]  w_diff;
  logic [EXT_W-1:0]  w_ml27;
  logic [EXT_W-1:0]  w_ms27;
  logic [EXT_W-1:0]  w_ms_sh;
  logic [EXT_W-1:0]  w_mask;
  logic              w_sticky;
  logic [EXT_W-1:0]  w_ms_al;
  logic              w_special;
  logic [31:0]       w_special_z;

  logic [4:0]        w_lz;
  logic [4:0]        w_norm_shift;
  logic [EXT_W-1:0]  w_norm_man;
  logic signed [9:0] w_norm_exp;

  logic              w_inc;
  logic [24:0]       w_rnd;
  logic signed [9:0] w_fin_exp;
  logic [22:0]       w_fin_frac;
  logic [31:0]       w_result;

  assign bus.input_a_ack  = r_a_ack;
  assign bus.input_b_ack  = r_b_ack;
  assign bus.output_z     = r_z;
  assign bus.output_z_stb = r_z_stb;

  assign w_a_fire = (r_state == GET_A) && bus.input_a_stb && r_a_ack;
  assign w_b_fire = (r_state == GET_B) && bus.input_b_stb && r_b_ack;

  assign w_sa     = fp_sign(r_a);
  assign w_sb     = fp_sign(r_b);
  assign w_ea     = fp_exp(r_a);
  assign w_eb     = fp_exp(r_b);
  assign w_fa     = fp_man(r_a);
  assign w_fb     = fp_man(r_b);
  assign w_a_zero = (w_ea == 8'd0);
  assign w_b_zero = (w_eb == 8'd0);
  assign w_a_inf  = (w_ea == 8'hFF) && (w_fa == 23'd0);
  assign w_b_inf  = (w_eb == 8'hFF) && (w_fb == 23'd0);
  assign w_a_nan  = (w_ea == 8'hFF) && (w_fa != 23'd0);
  assign w_b_nan  = (w_eb == 8'hFF) && (w_fb != 23'd0);
  assign w_ma     = w_a_zero ? 24'd0 : {1'b1, w_fa};
  assign w_mb     = w_b_zero ? 24'd0 : {1'b1, w_fb};
  assign w_a_ge   = ({w_ea, w_ma} >= {w_eb, w_mb});
  assign w_el     = w_a_ge ? w_ea : w_eb;
  assign w_es     = w_a_ge ? w_eb : w_ea;
  assign w_diff   = w_el - w_es;
  assign w_ml27   = {(w_a_ge ? w_ma : w_mb), 3'b000};
  assign w_ms27   = {(w_a_ge ? w_mb : w_ma), 3'b000};
  assign w_ms_al  = {w_ms_sh[EXT_W-1:1], w_ms_sh[0] | w_sticky};

  // Alignment shifter: bits pushed past the round position collapse into sticky.
  always_comb begin
    w_ms_sh  = 27'd0;
    w_mask   = 27'd0;
    w_sticky = 1'b0;
    if (w_diff >= 8'd27) begin
      w_sticky = (w_ms27 != 27'd0);
    end else begin
      w_mask   = (27'd1 << w_diff[4:0]) - 27'd1;
      w_ms_sh  = w_ms27 >> w_diff[4:0];
      w_sticky = ((w_ms27 & w_mask) != 27'd0);
    end
  end

  // Special-operand classification, resolved in ALIGN and carried to the result.
  always_comb begin
    w_special   = 1'b1;
    w_special_z = FP_QNAN;
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_sa != w_sb))) begin
      w_special_z = FP_QNAN;
    end else if (w_a_inf) begin
      w_special_z = r_a;
    end else if (w_b_inf) begin
      w_special_z = r_b;
    end else if (w_a_zero && w_b_zero) begin
      w_special_z = {w_sa & w_sb, 31'd0};
    end else if (w_a_zero) begin
      w_special_z = r_b;
    end else if (w_b_zero) begin
      w_special_z = r_a;
    end else begin
      w_special   = 1'b0;
      w_special_z = 32'd0;
    end
  end

  fpu_lzc28 u_lzc (
    .i_val (r_sum),
    .o_lz  (w_lz)
  );

  // Without carry the hidden bit belongs at bit 26, i.e. one below the lzc's MSB.
  assign w_norm_shift = w_lz - 5'd1;
  assign w_norm_man   = r_sum[EXT_W-1:0] << w_norm_shift;
  assign w_norm_exp   = r_exp - $signed({5'd0, w_norm_shift});

  assign w_inc      = r_man_l[2] & (r_man_l[1] | r_man_l[0] | r_man_l[3]);
  assign w_rnd      = {1'b0, r_man_l[EXT_W-1:3]} + {24'd0, w_inc};
  assign w_fin_exp  = w_rnd[24] ? (r_exp + 10'sd1) : r_exp;
  assign w_fin_frac = w_rnd[24] ? w_rnd[23:1] : w_rnd[22:0];

  // Final result selection for the value loaded into output_z.
  always_comb begin
    w_result = 32'd0;
    if (r_special) begin
      w_result = r_special_z;
    end else if (r_res_zero) begin
      w_result = {r_sign, 31'd0};
    end else if (w_fin_exp >= 10'sd255) begin
      w_result = {r_sign, FP_INF[30:0]};
    end else begin
      w_result = {r_sign, w_fin_exp[7:0], w_fin_frac};
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      GET_A:   w_next = w_a_fire ? GET_B : GET_A;
      GET_B:   w_next = w_b_fire ? ALIGN : GET_B;
      ALIGN:   w_next = ADD;
      ADD:     w_next = NORM;
      NORM:    w_next = ROUND;
      ROUND:   w_next = PUT_Z;
      PUT_Z:   w_next = GET_A;
      default: w_next = GET_A;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= GET_A;
    end else begin
      r_state <= w_next;
    end
  end

  // Datapath and registered handshake/result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_ack     <= 1'b0;
      r_b_ack     <= 1'b0;
      r_z_stb     <= 1'b0;
      r_z         <= 32'd0;
      r_a         <= 32'd0;
      r_b         <= 32'd0;
      r_special   <= 1'b0;
      r_special_z <= 32'd0;
      r_sign      <= 1'b0;
      r_sign_s    <= 1'b0;
      r_res_zero  <= 1'b0;
      r_exp       <= 10'sd0;
      r_man_l     <= 27'd0;
      r_man_s     <= 27'd0;
      r_sum       <= 28'd0;
    end else begin
      r_a_ack <= (w_next == GET_A);
      r_b_ack <= (w_next == GET_B);
      r_z_stb <= 1'b0;
      case (r_state)
        GET_A: begin
          if (w_a_fire) begin
            r_a <= bus.input_a;
          end
        end
        GET_B: begin
          if (w_b_fire) begin
            r_b <= bus.input_b;
          end
        end
        ALIGN: begin
          r_sign      <= w_a_ge ? w_sa : w_sb;
          r_sign_s    <= w_a_ge ? w_sb : w_sa;
          r_exp       <= $signed({2'b00, w_el});
          r_man_l     <= w_ml27;
          r_man_s     <= w_ms_al;
          r_special   <= w_special;
          r_special_z <= w_special_z;
        end
        ADD: begin
          if (r_sign == r_sign_s) begin
            r_sum <= {1'b0, r_man_l} + {1'b0, r_man_s};
          end else begin
            r_sum <= {1'b0, r_man_l} - {1'b0, r_man_s};
          end
        end
        NORM: begin
          if (r_sum[EXT_W]) begin
            r_man_l    <= {r_sum[EXT_W:2], r_sum[1] | r_sum[0]};
            r_exp      <= r_exp + 10'sd1;
            r_res_zero <= 1'b0;
          end else if (r_sum == 28'd0) begin
            r_res_zero <= 1'b1;
            r_sign     <= 1'b0;
          end else if (w_norm_exp <= 10'sd0) begin
            r_res_zero <= 1'b1;
          end else begin
            r_man_l    <= w_norm_man;
            r_exp      <= w_norm_exp;
            r_res_zero <= 1'b0;
          end
        end
        ROUND: begin
          r_z     <= w_result;
          r_z_stb <= 1'b1;
        end
        PUT_Z: begin
          r_z_stb <= 1'b0;
        end
        default: begin
          r_z_stb <= 1'b0;
        end
      endcase
    end
  end

endmodule
